// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing the single-port Mem-stage data memory between the pipeline
// load/store path and an auxiliary (RAM loader / debug) port. The pipeline
// wins by default; an aux requester that has waited STARVE_LIMIT cycles gets
// one forced slot that stalls the pipeline for that cycle.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_oper,
    input  logic              p_readmem,
    input  logic              p_writemem,
    input  logic [31:0]       p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [31:0]       a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              forced
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PIPE  = 2'd1,
        AUX   = 2'd2,
        FORCE = 2'd3
    } owner_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    owner_t     owner_q;
    owner_t     owner_d;
    logic [7:0] wait_cnt;
    logic       p_need;
    logic       p_wr;
    logic       unused_bits;

    assign p_need = p_oper & (p_readmem | p_writemem);
    // A simultaneous read and write request is treated as a load.
    assign p_wr   = p_writemem & ~p_readmem;

    // Address bits outside the word index are not decoded; owner_q is a status
    // copy of the previous owner, kept for hierarchical observation only.
    assign unused_bits = ^{p_addr[31:ADDR_W+2], p_addr[1:0],
                           a_addr[31:ADDR_W+2], a_addr[1:0], owner_q};

    // Decide this cycle's memory owner; reset forces IDLE so no write can slip through.
    always_comb begin
        // NOTE: default assigned first so every path drives owner_d and no latch is inferred.
        owner_d = IDLE;
        if (!reset)
            owner_d = IDLE;
        else if (a_req && (wait_cnt == LIMIT))
            owner_d = FORCE;
        else if (p_need)
            owner_d = PIPE;
        else if (a_req)
            owner_d = AUX;
    end

    // Drive memory pins, grant, stall and status from the chosen owner.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        a_gnt     = 1'b0;
        p_stall   = 1'b0;
        forced    = 1'b0;
        case (owner_d)
            PIPE: begin
                mem_addr  = p_addr[ADDR_W+1:2];
                mem_wdata = p_wdata;
                mem_we    = p_wr;
            end
            AUX: begin
                mem_addr  = a_addr[ADDR_W+1:2];
                mem_wdata = a_wdata;
                mem_we    = a_we;
                a_gnt     = 1'b1;
            end
            FORCE: begin
                mem_addr  = a_addr[ADDR_W+1:2];
                mem_wdata = a_wdata;
                mem_we    = a_we;
                a_gnt     = 1'b1;
                p_stall   = p_need;
                forced    = 1'b1;
            end
            default: ;
        endcase
    end

    // Register the previous cycle's owner for status.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset)
            owner_q <= IDLE;
        else
            owner_q <= owner_d;
    end

    // Count cycles the aux requester has been refused; saturate at the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            wait_cnt <= 8'd0;
        else if (a_gnt || !a_req)
            wait_cnt <= 8'd0;
        else if (wait_cnt != LIMIT)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // Capture aux read data one cycle after a read grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            if (a_gnt && !a_we)
                a_rdata <= mem_rdata;
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port 128-word data memory of the Mem stage between two requesters: the pipeline load/store path and an auxiliary port (RAM loader / debug access).
- The pipeline has priority. A starvation counter forces one aux slot, stalling the pipeline for one cycle, once the aux requester has waited STARVE_LIMIT cycles.
- Sits between the Mem_0/Mem_1 pipeline registers and the memory instance, and drives all memory control pins.

Parameters:
- ADDR_W, 7, word-address width driven to memory; uses byte address bits [ADDR_W+1:2].
- DATA_W, 32, data width.
- STARVE_LIMIT, 8, aux wait cycles before a forced grant; legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- p_oper  in  1  pipeline Mem stage holds a valid instruction.
- p_readmem  in  1  pipeline load.
- p_writemem  in  1  pipeline store.
- p_addr  in  32  pipeline byte address.
- p_wdata  in  DATA_W  pipeline store data.
- p_stall  out  1  pipeline must hold its Mem stage this cycle.
- a_req  in  1  aux access request; held until granted.
- a_we  in  1  aux write (1) or read (0).
- a_addr  in  32  aux byte address.
- a_wdata  in  DATA_W  aux write data.
- a_gnt  out  1  aux access performed this cycle.
- a_rvalid  out  1  aux read data valid (one cycle).
- a_rdata  out  DATA_W  aux read data.
- mem_addr  out  ADDR_W  word address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  combinational read data from memory.
- forced  out  1  current cycle is a forced aux slot (status).

Behaviour:
- Definitions:
  - p_need = p_oper & (p_readmem | p_writemem).
  - p_wr = p_writemem & ~p_readmem. Read has precedence when both are set.
- Registered state:
  - wait_cnt: 8 bits, saturating at STARVE_LIMIT.
  - a_rvalid, a_rdata.
  - owner FSM: IDLE, PIPE, AUX, FORCE. The FSM is the registered copy of the previous cycle's owner, used for status and test. Ownership itself is decided combinationally each cycle.
- Owner decision, priority order:
  - (1) FORCE if a_req & wait_cnt==STARVE_LIMIT.
  - (2) PIPE if p_need.
  - (3) AUX if a_req.
  - (4) IDLE otherwise.
- Outputs by owner:
  - PIPE: mem_addr=p_addr[ADDR_W+1:2], mem_wdata=p_wdata, mem_we=p_wr, a_gnt=0, p_stall=0.
  - AUX and FORCE: mem_addr=a_addr[ADDR_W+1:2], mem_wdata=a_wdata, mem_we=a_we, a_gnt=1.
  - p_stall=p_need in FORCE, 0 in AUX.
  - forced=1 only in FORCE.
  - IDLE: mem_we=0, mem_addr=0, mem_wdata=0, a_gnt=0, p_stall=0.
- Aux read return:
  - If a_gnt & ~a_we at a rising edge: a_rdata <= mem_rdata and a_rvalid <= 1 in the next cycle. Read latency is 1 cycle after grant.
  - Otherwise a_rvalid <= 0; a_rdata holds its value.
- Write timing: memory write commits at the rising edge of the granted cycle.
- wait_cnt update:
  - Cleared when a_gnt or ~a_req.
  - Incremented when a_req & ~a_gnt, saturating at STARVE_LIMIT.
- Back-to-back forced grants are impossible: a grant clears wait_cnt, so the pipeline gets at least STARVE_LIMIT cycles between forced stalls.
- Reset (async, active-low): owner=IDLE, wait_cnt=0, a_rvalid=0, a_rdata=0. All combinational outputs follow the IDLE values while reset is low.
- Reset mid-operation: a pending aux read return is dropped (a_rvalid=0). Any memory write in the reset cycle is suppressed, since mem_we is forced to 0 while reset is low.
- Aux address/data changing while a_req is high and ungranted is a protocol violation and is not checked.
- Pipeline contract: p_stall is combinational. When p_stall=1, the pipeline holds m0_m1_* unchanged and Mem_1 treats the cycle as a bubble.

Test Plan:
- Reset, then idle: reset low for 2 cycles with a_req=1 and p_need=1 → all outputs 0, mem_we=0. After release with no requests → owner IDLE, a_rvalid=0.
- Pipeline store then load: p_oper=1, p_writemem=1, p_addr=0x10, p_wdata=0xDEADBEEF → mem_addr=4, mem_we=1. Next cycle a load from 0x10 → mem_rdata=0xDEADBEEF, p_stall=0, a_gnt=0.
- Aux read while pipeline idle: a_req=1, a_we=0, a_addr=0x1FC → a_gnt=1 same cycle, mem_addr=127. Next cycle a_rvalid=1 with a_rdata equal to memory[127], then a_rvalid=0.
- Contention and starvation: p_need=1 every cycle, a_req=1 write of 0x12345678 to 0x20 → a_gnt=0 for 8 cycles. Cycle 9: forced=1, p_stall=1, a_gnt=1, mem_we=1, mem_addr=8. Cycle 10: p_stall=0 and wait_cnt=0.
- Read/write precedence: p_readmem=1 and p_writemem=1 together → mem_we=0 (treated as a load).
- Reset mid-read: aux read granted, reset asserted before the next edge → a_rvalid stays 0 after release, and wait_cnt=0.
